// File: rtl/dmux16_router_pkg.sv
// dmux16_router_pkg: shared FIFO state encodings and default sizes for the word demux.
package dmux16_router_pkg;
   localparam int WIDTH_DEF = 16;
   localparam int DEPTH_DEF = 2;
   localparam int CNT_W_DEF = 8;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} fifo_state_e;
endpackage

// File: rtl/dmux16_router_fifo.sv
// fifo2x16: two-entry word FIFO; head register feeds the output, tail register holds the second word.
module fifo2x16
   import dmux16_router_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             valid,
   output logic             full
);
   fifo_state_e      state_q, state_d;
   logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
   logic             do_push, do_pop;
   assign do_push = push & (state_q != FULL);
   assign do_pop  = pop & (state_q != EMPTY);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         EMPTY: if (do_push) begin
            head_d  = din;
            state_d = ONE;
         end
         // push with pop in ONE replaces the head directly, bypassing the tail
         ONE: if (do_push & do_pop) head_d = din;
            else if (do_push) begin
               tail_d  = din;
               state_d = FULL;
            end else if (do_pop) state_d = EMPTY;
         FULL: if (do_pop) begin
            head_d  = tail_q;
            state_d = ONE;
         end
         default: state_d = EMPTY;
      endcase
   end
   assign head  = head_q;
   assign valid = state_q != EMPTY;
   assign full  = state_q == FULL;
endmodule

// File: rtl/dmux16_router.sv
// dmux16_router: steers a valid/ready word stream by in_sel into two FIFO-buffered channels
// (in_sel=1 -> a, 0 -> b) with per-channel accepted-word counters.
module dmux16_router
   import dmux16_router_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] b_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [CNT_W-1:0] a_count,
   output logic [CNT_W-1:0] b_count
);
   if (DEPTH != 2) begin : g_bad_depth
      $error("dmux16_router: DEPTH is fixed at 2");
   end
   logic             a_full, b_full, push_a, push_b;
   logic [CNT_W-1:0] a_count_q, a_count_d, b_count_q, b_count_d;
   // ready depends only on registered fullness, never on the consumers' ready
   assign in_ready = in_sel ? ~a_full : ~b_full;
   assign push_a   = in_valid & in_ready & in_sel;
   assign push_b   = in_valid & in_ready & ~in_sel;
   fifo2x16 #(.WIDTH(WIDTH)) u_fifo_a (
      .clk(clk), .reset(reset), .push(push_a), .din(in_data), .pop(a_valid & a_ready),
      .head(a_data), .valid(a_valid), .full(a_full)
   );
   fifo2x16 #(.WIDTH(WIDTH)) u_fifo_b (
      .clk(clk), .reset(reset), .push(push_b), .din(in_data), .pop(b_valid & b_ready),
      .head(b_data), .valid(b_valid), .full(b_full)
   );
   always_comb begin
      a_count_d = a_count_q + CNT_W'(push_a);
      b_count_d = b_count_q + CNT_W'(push_b);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         a_count_q <= '0;
         b_count_q <= '0;
      end else begin
         a_count_q <= a_count_d;
         b_count_q <= b_count_d;
      end
   assign a_count = a_count_q;
   assign b_count = b_count_q;
endmodule

// File: tb/tb_dmux16_router.sv
// tb_dmux16_router: directed scenarios for the word demux with hand-computed expectations.
module tb_dmux16_router;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] in_data = '0;
   logic        in_sel = 1'b0, in_valid = 1'b0, a_ready = 1'b0, b_ready = 1'b0;
   logic        in_ready, a_valid, b_valid;
   logic [15:0] a_data, b_data;
   logic [7:0]  a_count, b_count;
   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   dmux16_router dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready), .a_count(a_count), .b_count(b_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 0; in_sel = 0; in_data = 0; a_ready = 0; b_ready = 0;
      @(posedge clk);
      #1 reset = 1;
      @(posedge clk);
      #1 reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got a=%b b=%b want 0 0", a_valid, b_valid); end
      n_cmp++; if (a_data !== 16'h0 || b_data !== 16'h0) begin n_bad++; $display("FAIL reset_data got a=%h b=%h want 0000 0000", a_data, b_data); end
      n_cmp++; if (a_count !== 8'd0 || b_count !== 8'd0) begin n_bad++; $display("FAIL reset_count got a=%0d b=%0d want 0 0", a_count, b_count); end
      in_sel = 1; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_sel1 got %b want 1", in_ready); end
      in_sel = 0; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_sel0 got %b want 1", in_ready); end
   endtask

   task automatic test_single();
      do_reset();
      in_valid = 1; in_sel = 1; in_data = 16'hAAAA; a_ready = 1;
      tick();
      in_valid = 0;
      n_cmp++; if (a_valid !== 1'b1 || a_data !== 16'hAAAA) begin n_bad++; $display("FAIL single_a got v=%b d=%h want 1 AAAA", a_valid, a_data); end
      n_cmp++; if (a_count !== 8'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", a_count); end
      n_cmp++; if (b_valid !== 1'b0) begin n_bad++; $display("FAIL single_b_valid got %b want 0", b_valid); end
      tick();
      n_cmp++; if (a_valid !== 1'b0 || a_data !== 16'hAAAA) begin n_bad++; $display("FAIL single_pop got v=%b d=%h want 0 AAAA", a_valid, a_data); end
   endtask

   task automatic test_fill_a();
      do_reset();
      in_valid = 1; in_sel = 1; in_data = 16'h0001;
      tick();
      in_data = 16'h0002;
      tick();
      in_data = 16'h0003; #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full_ready got %b want 0", in_ready); end
      n_cmp++; if (a_count !== 8'd2 || a_data !== 16'h0001) begin n_bad++; $display("FAIL fill_state got cnt=%0d d=%h want 2 0001", a_count, a_data); end
      a_ready = 1; #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready_no_comb got %b want 0", in_ready); end
      tick();
      n_cmp++; if (a_data !== 16'h0002 || in_ready !== 1'b1 || a_count !== 8'd2) begin n_bad++; $display("FAIL fill_pop1 got d=%h rdy=%b cnt=%0d want 0002 1 2", a_data, in_ready, a_count); end
      tick();
      in_valid = 0;
      n_cmp++; if (a_data !== 16'h0003 || a_count !== 8'd3 || a_valid !== 1'b1) begin n_bad++; $display("FAIL fill_pop2 got d=%h cnt=%0d v=%b want 0003 3 1", a_data, a_count, a_valid); end
      tick();
      n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL fill_drain got %b want 0", a_valid); end
   endtask

   task automatic test_stall();
      do_reset();
      b_ready = 1; in_valid = 1; in_sel = 1; in_data = 16'hA001;
      tick();
      in_data = 16'hA002;
      tick();
      in_sel = 0; in_data = 16'hB001; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_b_while_a_full got %b want 1", in_ready); end
      tick();
      n_cmp++; if (b_valid !== 1'b1 || b_data !== 16'hB001 || b_count !== 8'd1) begin n_bad++; $display("FAIL stall_b_accept got v=%b d=%h cnt=%0d want 1 B001 1", b_valid, b_data, b_count); end
      in_sel = 1; in_data = 16'hA003; #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_a_ready got %b want 0", in_ready); end
      tick();
      n_cmp++; if (a_count !== 8'd2 || b_valid !== 1'b0) begin n_bad++; $display("FAIL stall_hold got cnt=%0d bv=%b want 2 0", a_count, b_valid); end
      a_ready = 1;
      tick();
      n_cmp++; if (in_ready !== 1'b1 || a_data !== 16'hA002) begin n_bad++; $display("FAIL stall_drain got rdy=%b d=%h want 1 A002", in_ready, a_data); end
      tick();
      n_cmp++; if (a_count !== 8'd3 || a_data !== 16'hA003) begin n_bad++; $display("FAIL stall_resume got cnt=%0d d=%h want 3 A003", a_count, a_data); end
      in_sel = 0; in_data = 16'hB002; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_b_after_ready got %b want 1", in_ready); end
      tick();
      in_valid = 0;
      n_cmp++; if (b_data !== 16'hB002 || b_count !== 8'd2 || a_valid !== 1'b0) begin n_bad++; $display("FAIL stall_b_after got d=%h cnt=%0d av=%b want B002 2 0", b_data, b_count, a_valid); end
   endtask

   task automatic test_stream_b();
      int errs = 0;
      do_reset();
      b_ready = 1; in_valid = 1; in_sel = 0;
      for (int i = 0; i < 300; i++) begin
         in_data = 16'h4000 + 16'(i); #1;
         n_cmp++; if (in_ready !== 1'b1) begin n_bad++; errs++; if (errs < 5) $display("FAIL stream_bubble at %0d got %b want 1", i, in_ready); end
         tick();
         n_cmp++; if (b_valid !== 1'b1 || b_data !== 16'h4000 + 16'(i)) begin n_bad++; errs++; if (errs < 5) $display("FAIL stream_data at %0d got v=%b d=%h want 1 %h", i, b_valid, b_data, 16'h4000 + 16'(i)); end
      end
      in_valid = 0;
      n_cmp++; if (b_count !== 8'd44 || a_count !== 8'd0) begin n_bad++; $display("FAIL stream_count got b=%0d a=%0d want 44 0", b_count, a_count); end
      tick();
      n_cmp++; if (b_valid !== 1'b0) begin n_bad++; $display("FAIL stream_end got %b want 0", b_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid = 1; in_sel = 1; in_data = 16'hC001; tick();
      in_data = 16'hC002; tick();
      in_sel = 0; in_data = 16'hD001; tick();
      in_data = 16'hD002; tick();
      in_valid = 0;
      n_cmp++; if (a_count !== 8'd2 || b_count !== 8'd2 || !a_valid || !b_valid) begin n_bad++; $display("FAIL mid_fill got a=%0d b=%0d av=%b bv=%b want 2 2 1 1", a_count, b_count, a_valid, b_valid); end
      #3 reset = 1;
      #1;
      n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got a=%b b=%b want 0 0", a_valid, b_valid); end
      n_cmp++; if (a_count !== 8'd0 || b_count !== 8'd0 || a_data !== 16'h0 || b_data !== 16'h0) begin n_bad++; $display("FAIL mid_clear got a=%0d b=%0d ad=%h bd=%h want 0 0 0000 0000", a_count, b_count, a_data, b_data); end
      @(posedge clk);
      #1 reset = 0;
      in_sel = 1; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_a got %b want 1", in_ready); end
      in_sel = 0; in_valid = 1; in_data = 16'h5A5A; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_b got %b want 1", in_ready); end
      tick();
      in_valid = 0;
      n_cmp++; if (b_valid !== 1'b1 || b_data !== 16'h5A5A || a_valid !== 1'b0 || b_count !== 8'd1) begin n_bad++; $display("FAIL mid_route got bv=%b bd=%h av=%b cnt=%0d want 1 5A5A 0 1", b_valid, b_data, a_valid, b_count); end
   endtask

   task automatic test_one_state();
      logic [15:0] prev, d;
      int errs = 0;
      do_reset();
      in_valid = 1; in_sel = 1; in_data = 16'h1234;
      tick();
      a_ready = 1; prev = 16'h1234;
      for (int k = 0; k < 100; k++) begin
         d = (k % 2 == 0) ? 16'hFFFF : 16'h1234;
         in_data = d; #1;
         n_cmp++; if (in_ready !== 1'b1 || a_valid !== 1'b1 || a_data !== prev) begin n_bad++; errs++; if (errs < 5) $display("FAIL one_state at %0d got rdy=%b v=%b d=%h want 1 1 %h", k, in_ready, a_valid, a_data, prev); end
         tick();
         prev = d;
      end
      in_valid = 0;
      n_cmp++; if (a_data !== 16'h1234 || a_count !== 8'd101) begin n_bad++; $display("FAIL one_final got d=%h cnt=%0d want 1234 101", a_data, a_count); end
      tick();
      n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL one_drain got %b want 0", a_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_a();
      test_stall();
      test_stream_b();
      test_reset_mid();
      test_one_state();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
